// File: rtl/dst_shift_reg.sv
// Gathers four 16-lane ALU result chunks into one 64-lane wavefront result.
// Latency: valid one cycle after the fourth chunk; ready drops while a result waits for wb_ack.
module dst_shift_reg #(
   parameter int WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  alu_dest_valid,
   input  logic [16*WIDTH-1:0]   alu_vgpr_dest_data,
   input  logic [15:0]           alu_sgpr_dest_data,
   input  logic [15:0]           alu_dest_wr_mask,
   input  logic                  dst_buffer_clear,
   input  logic                  wb_ack,
   output logic                  dst_buffer_ready,
   output logic [64*WIDTH-1:0]   vgpr_dest_data,
   output logic [63:0]           sgpr_dest_data,
   output logic [63:0]           dest_wr_mask,
   output logic                  dst_buffer_valid
);

   typedef enum logic {COLLECT = 1'b0, FULL = 1'b1} state_t;

   state_t                state_q;
   logic [1:0]            cnt_q;
   logic [1:0]            cnt_d;
   logic                  valid_q;
   logic [64*WIDTH-1:0]   vgpr_q;
   logic [63:0]           sgpr_q;
   logic [63:0]           mask_q;
   logic                  accept;

   // A waiting result frees the buffer in the same cycle writeback takes it.
   assign dst_buffer_ready = !dst_buffer_clear && ((state_q == COLLECT) || wb_ack);
   assign accept           = alu_dest_valid && dst_buffer_ready;
   assign cnt_d            = cnt_q + 2'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= COLLECT;
         cnt_q   <= 2'd0;
         valid_q <= 1'b0;
         vgpr_q  <= '0;
         sgpr_q  <= '0;
         mask_q  <= '0;
      end else if (dst_buffer_clear) begin
         state_q <= COLLECT;
         cnt_q   <= 2'd0;
         valid_q <= 1'b0;
      end else begin
         // cnt is zero whenever FULL, so an ack-plus-accept lands in lanes 0..15.
         for (int k = 0; k < 4; k++) begin
            if (accept && (cnt_q == 2'(k))) begin
               vgpr_q[k*16*WIDTH +: 16*WIDTH] <= alu_vgpr_dest_data;
               sgpr_q[k*16 +: 16]             <= alu_sgpr_dest_data;
               mask_q[k*16 +: 16]             <= alu_dest_wr_mask;
            end
         end
         if (accept) begin
            cnt_q <= cnt_d;
         end
         if (accept && (cnt_q == 2'd3)) begin
            state_q <= FULL;
            valid_q <= 1'b1;
         end else if ((state_q == FULL) && wb_ack) begin
            state_q <= COLLECT;
            valid_q <= 1'b0;
         end
      end
   end

   assign vgpr_dest_data   = vgpr_q;
   assign sgpr_dest_data   = sgpr_q;
   assign dest_wr_mask     = mask_q;
   assign dst_buffer_valid = valid_q;

endmodule

// File: tb/tb_dst_shift_reg.sv
// Directed-vector bench for dst_shift_reg with hand-computed expectations.
module tb_dst_shift_reg;
   localparam int W = 32;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_dest_valid;
   logic [16*W-1:0] alu_vgpr_dest_data;
   logic [15:0]     alu_sgpr_dest_data;
   logic [15:0]     alu_dest_wr_mask;
   logic            dst_buffer_clear;
   logic            wb_ack;
   logic            dst_buffer_ready;
   logic [64*W-1:0] vgpr_dest_data;
   logic [63:0]     sgpr_dest_data;
   logic [63:0]     dest_wr_mask;
   logic            dst_buffer_valid;

   int n_vec = 0;
   int n_err = 0;

   dst_shift_reg #(.WIDTH(W)) dut (
      .clk                (clk),
      .rst                (rst),
      .alu_dest_valid     (alu_dest_valid),
      .alu_vgpr_dest_data (alu_vgpr_dest_data),
      .alu_sgpr_dest_data (alu_sgpr_dest_data),
      .alu_dest_wr_mask   (alu_dest_wr_mask),
      .dst_buffer_clear   (dst_buffer_clear),
      .wb_ack             (wb_ack),
      .dst_buffer_ready   (dst_buffer_ready),
      .vgpr_dest_data     (vgpr_dest_data),
      .sgpr_dest_data     (sgpr_dest_data),
      .dest_wr_mask       (dest_wr_mask),
      .dst_buffer_valid   (dst_buffer_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] lane(input int l);
      return 64'(vgpr_dest_data[l*W +: W]);
   endfunction

   // Chunk lanes carry base + global lane index (16k + i).
   task automatic drive(input logic v, input int k, input logic [31:0] base,
                        input logic [15:0] s, input logic [15:0] m,
                        input logic ack, input logic clr);
      alu_dest_valid   = v;
      for (int i = 0; i < 16; i++)
         alu_vgpr_dest_data[i*W +: W] = base + 32'(16*k + i);
      alu_sgpr_dest_data = s;
      alu_dest_wr_mask   = m;
      wb_ack             = ack;
      dst_buffer_clear   = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 0, 32'h0, 16'h0, 16'h0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b0;
      idle();
      #1;
      check("rst_valid", 64'(dst_buffer_valid), 64'd0);
      check("rst_ready", 64'(dst_buffer_ready), 64'd1);
      check("rst_sgpr", sgpr_dest_data, 64'd0);
      check("rst_mask", dest_wr_mask, 64'd0);
      check("rst_lane63", lane(63), 64'd0);
      tick();
      tick();
      rst = 1'b1;
      tick();
      check("post_rst_ready", 64'(dst_buffer_ready), 64'd1);

      // Four back-to-back chunks
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, k, 32'h1000 * k, 16'hA5A5, 16'hFFFF, 1'b0, 1'b0);
         #1;
         check("b2b_ready", 64'(dst_buffer_ready), 64'd1);
         tick();
         check("b2b_valid", 64'(dst_buffer_valid), (k == 3) ? 64'd1 : 64'd0);
      end
      check("b2b_lane37", lane(37), 64'h2025);
      check("b2b_lane0", lane(0), 64'h0000);
      check("b2b_sgpr", sgpr_dest_data, 64'hA5A5A5A5A5A5A5A5);
      check("b2b_mask", dest_wr_mask, 64'hFFFFFFFFFFFFFFFF);

      // Held in FULL without ack
      for (int c = 0; c < 3; c++) begin
         drive(1'b1, 0, 32'hB000, 16'h5555, 16'h0F0F, 1'b0, 1'b0);
         #1;
         check("full_ready", 64'(dst_buffer_ready), 64'd0);
         tick();
         check("full_valid", 64'(dst_buffer_valid), 64'd1);
         check("full_lane0", lane(0), 64'h0000);
         check("full_lane37", lane(37), 64'h2025);
      end
      check("full_sgpr", sgpr_dest_data, 64'hA5A5A5A5A5A5A5A5);

      // Ack with a new chunk in the same cycle
      drive(1'b1, 0, 32'hC000, 16'h1234, 16'h00FF, 1'b1, 1'b0);
      #1;
      check("ack_ready", 64'(dst_buffer_ready), 64'd1);
      tick();
      check("ack_valid", 64'(dst_buffer_valid), 64'd0);
      check("ack_lane0", lane(0), 64'hC000);
      check("ack_lane16", lane(16), 64'h1010);
      check("ack_sgpr", sgpr_dest_data, 64'hA5A5A5A5A5A51234);
      check("ack_mask", dest_wr_mask, 64'hFFFFFFFFFFFF00FF);
      for (int k = 1; k < 4; k++) begin
         drive(1'b1, k, 32'hD000, 16'h1234, 16'h00FF, 1'b0, 1'b0);
         tick();
         check("cnt1_valid", 64'(dst_buffer_valid), (k == 3) ? 64'd1 : 64'd0);
      end
      check("cnt1_lane16", lane(16), 64'hD010);
      check("cnt1_lane0", lane(0), 64'hC000);
      drive(1'b0, 0, 32'h0, 16'h0, 16'h0, 1'b1, 1'b0);
      tick();
      check("drain_valid", 64'(dst_buffer_valid), 64'd0);

      // Clear mid-collection
      for (int k = 0; k < 2; k++) begin
         drive(1'b1, k, 32'hE000, 16'h0000, 16'h0000, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 2, 32'hF000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
      #1;
      check("clr_ready", 64'(dst_buffer_ready), 64'd0);
      tick();
      check("clr_lane32", lane(32), 64'hD020);
      check("clr_lane16", lane(16), 64'hE010);
      drive(1'b1, 0, 32'h5000, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
      check("clr_lane0", lane(0), 64'h5000);
      check("clr_lane16b", lane(16), 64'hE010);
      for (int k = 1; k < 4; k++) begin
         drive(1'b1, k, 32'h5000, 16'h0000, 16'h0000, 1'b0, 1'b0);
         tick();
         check("clr_valid", 64'(dst_buffer_valid), (k == 3) ? 64'd1 : 64'd0);
      end
      drive(1'b0, 0, 32'h0, 16'h0, 16'h0, 1'b1, 1'b0);
      tick();

      // Gapped chunks; stray wb_ack during gaps must be ignored
      for (int k = 0; k < 4; k++) begin
         logic [15:0] m;
         case (k)
            0:       m = 16'h0001;
            1:       m = 16'h0000;
            2:       m = 16'hFFFF;
            default: m = 16'h8000;
         endcase
         drive(1'b1, k, 32'h7000, 16'h0000, m, 1'b0, 1'b0);
         tick();
         if (k < 3) begin
            for (int g = 0; g < 2; g++) begin
               drive(1'b0, 0, 32'h0, 16'h0, 16'h0, 1'b1, 1'b0);
               tick();
               check("gap_valid", 64'(dst_buffer_valid), 64'd0);
            end
         end
      end
      check("gap_valid_end", 64'(dst_buffer_valid), 64'd1);
      check("gap_mask", dest_wr_mask, 64'h8000FFFF00000001);
      check("gap_lane63", lane(63), 64'h703F);
      drive(1'b0, 0, 32'h0, 16'h0, 16'h0, 1'b1, 1'b0);
      tick();

      // Asynchronous reset mid-collection
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, k, 32'h9000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
         tick();
      end
      idle();
      #2;
      rst = 1'b0;
      #1;
      check("arst_valid", 64'(dst_buffer_valid), 64'd0);
      check("arst_mask", dest_wr_mask, 64'd0);
      check("arst_sgpr", sgpr_dest_data, 64'd0);
      check("arst_lane0", lane(0), 64'd0);
      check("arst_ready", 64'(dst_buffer_ready), 64'd1);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, k, 32'h3000, 16'h0F0F, 16'h00FF, 1'b0, 1'b0);
         tick();
         check("arst_fill", 64'(dst_buffer_valid), (k == 3) ? 64'd1 : 64'd0);
         if (k == 0) check("arst_lane0b", lane(0), 64'h3000);
      end
      check("arst_sgpr_end", sgpr_dest_data, 64'h0F0F0F0F0F0F0F0F);
      idle();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1);
   end

endmodule
